// File: rtl/ram_fifo_ctrl_if.sv
// Write/read handshake bundle between a FIFO producer/consumer and ram_fifo_ctrl.
// The slave modport is the FIFO side; master is the agent driving it.
interface ram_fifo_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller around an external dual-port RAM (port A write, port B registered read).
// Latency: word readable 2 edges after it is offered to an empty FIFO; s_ready drops at level==DEPTH.
// Optional almost_full/almost_empty flags are built only with FIFO_ALMOST_FLAGS_EN defined.
module ram_fifo_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              reset,
    ram_fifo_ctrl_if.slave    bus,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_wr_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_data_b,
    output logic              ram_wr_b,
    input  logic [DATA_W-1:0] ram_q_b,
    output logic [ADDR_W:0]   level
`ifdef FIFO_ALMOST_FLAGS_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

    if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
        $error("ram_fifo_ctrl: AE_LEVEL must be below AF_LEVEL");
    end

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] level_q, level_d;
    logic [ADDR_W:0] rd_next;
    logic            s_ready_q, s_ready_d;
    logic            m_valid_q, m_valid_d;
    logic            push, pop;

    always_comb begin
        push     = bus.s_valid & s_ready_q;
        pop      = m_valid_q & bus.m_ready;
        rd_next  = rd_ptr_q + ONE;
        wr_ptr_d = push ? (wr_ptr_q + ONE) : wr_ptr_q;
        rd_ptr_d = pop ? rd_next : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + ONE;
            2'b01:   level_d = level_q - ONE;
            default: level_d = level_q;
        endcase
        // s_ready is registered so it stays low through reset and the first edge after it.
        s_ready_d = (level_d < FULL_LVL);
        // Head is valid next cycle only if it was written before this edge and survives the pop.
        m_valid_d = pop ? (level_q > ONE) : (level_q != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
        end
    end

    // Read address runs one ahead on a pop so ram_q_b already holds the new head.
    assign ram_addr_b  = pop ? rd_next[ADDR_W-1:0] : rd_ptr_q[ADDR_W-1:0];
    assign ram_data_b  = '0;
    assign ram_wr_b    = 1'b0;
    assign ram_addr_a  = wr_ptr_q[ADDR_W-1:0];
    assign ram_data_a  = bus.s_data;
    assign ram_wr_a    = push;
    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = ram_q_b;
    assign level       = level_q;

`ifdef FIFO_ALMOST_FLAGS_EN
    localparam logic [ADDR_W:0] AF_W = AF_LEVEL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_W = AE_LEVEL[ADDR_W:0];

    logic almost_full_q, almost_full_d;
    logic almost_empty_q, almost_empty_d;

    always_comb begin
        almost_full_d  = (level_d >= AF_W);
        almost_empty_d = (level_d <= AE_W);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end

    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif

endmodule
